// File: rtl/full_st0_ctrl_sequencer.sv
// Stage-0 pass sequencer: load one input block, issue one tap read per tap,
// drain the MAC pipeline, then pulse state_finish and advance load_phase.
module full_st0_ctrl_sequencer #(
  parameter int unsigned PIPE_DEPTH = 6,
  parameter int unsigned PHASES     = 4,
  localparam int unsigned PHASE_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [3:0]         tap_length,
  input  logic [2:0]         load_length,
  input  logic               stage_0_data_vld,
  output logic               stage_0_data_rdy,
  input  logic               stall,
  input  logic               error_update_mode,
  output logic [3:0]         read_address,
  output logic               read_valid,
  output logic               read_finish,
  output logic               state_finish,
  output logic               update_pass,
  output logic [PHASE_W-1:0] load_phase,
  output logic               busy
);

  localparam logic [3:0]         DRAIN_INIT = 4'(PIPE_DEPTH - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StFin
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sample_q, sample_d;
  logic [3:0]         addr_q, addr_d;
  logic [3:0]         drain_q, drain_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               upd_q, upd_d;
  logic               busy_q;
  logic               fin_q;

  logic handshake;
  logic last_sample;
  logic last_tap;

  assign stage_0_data_rdy = (state_q == StLoad);
  assign handshake        = stage_0_data_rdy & stage_0_data_vld;
  assign last_sample      = (sample_q == load_length);
  assign read_valid       = (state_q == StRun) & ~stall;
  assign last_tap         = (addr_q == tap_length);
  assign read_finish      = read_valid & last_tap;

  assign read_address = addr_q;
  assign state_finish = fin_q;
  assign update_pass  = upd_q;
  assign load_phase   = phase_q;
  assign busy         = busy_q;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    addr_d   = addr_q;
    drain_d  = drain_q;
    phase_d  = phase_q;
    upd_d    = upd_q;
    unique case (state_q)
      StIdle: begin
        sample_d = 3'd0;
        if (enable) state_d = StLoad;
      end
      StLoad: begin
        if (handshake) begin
          if (last_sample) begin
            sample_d = 3'd0;
            addr_d   = 4'd0;
            upd_d    = error_update_mode;
            state_d  = StRun;
          end else begin
            sample_d = sample_q + 3'd1;
          end
        end
      end
      StRun: begin
        if (read_valid) begin
          addr_d = addr_q + 4'd1;
          if (last_tap) begin
            drain_d = DRAIN_INIT;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Down-counter runs PIPE_DEPTH cycles regardless of stall.
        if (drain_q == 4'd0) begin
          state_d = StFin;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      StFin: begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        state_d = enable ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sample_q <= 3'd0;
      addr_q   <= 4'd0;
      drain_q  <= 4'd0;
      phase_q  <= '0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      addr_q   <= addr_d;
      drain_q  <= drain_d;
      phase_q  <= phase_d;
      upd_q    <= upd_d;
      // Registered decodes of the next state so they line up with state_q.
      busy_q   <= (state_d != StIdle);
      fin_q    <= (state_d == StFin);
    end
  end

endmodule

// File: tb/tb_full_st0_ctrl_sequencer.sv
// Directed bench for full_st0_ctrl_sequencer: expected reads and pass ends are
// queued when a pass is launched and checked by a negedge monitor.
module tb_full_st0_ctrl_sequencer;

  localparam int PD = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] tap_length;
  logic [2:0] load_length;
  logic       stage_0_data_vld;
  logic       stage_0_data_rdy;
  logic       stall;
  logic       error_update_mode;
  logic [3:0] read_address;
  logic       read_valid;
  logic       read_finish;
  logic       state_finish;
  logic       update_pass;
  logic [1:0] load_phase;
  logic       busy;

  full_st0_ctrl_sequencer #(
    .PIPE_DEPTH(PD),
    .PHASES    (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .tap_length       (tap_length),
    .load_length      (load_length),
    .stage_0_data_vld (stage_0_data_vld),
    .stage_0_data_rdy (stage_0_data_rdy),
    .stall            (stall),
    .error_update_mode(error_update_mode),
    .read_address     (read_address),
    .read_valid       (read_valid),
    .read_finish      (read_finish),
    .state_finish     (state_finish),
    .update_pass      (update_pass),
    .load_phase       (load_phase),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] addr;
    logic       last;
    logic       upd;
  } rd_t;

  typedef struct packed {
    logic [1:0] phase;
    logic       upd;
  } fin_t;

  rd_t  exp_rd_q[$];
  fin_t exp_fin_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rf_cyc = -100;
  int rd_cnt = 0;
  int rf_cnt = 0;
  int fin_count = 0;
  int hs_count = 0;
  int rdy_cycles = 0;
  logic [1:0] exp_phase = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL timeout_%s: event not seen within cycle budget", tag);
  endtask

  // Monitor: consumes the scoreboard as the DUT produces reads and pass ends.
  always @(negedge clk) begin
    rd_t  e;
    fin_t f;
    cyc++;
    if (stage_0_data_rdy === 1'b1) rdy_cycles++;
    if (stage_0_data_rdy === 1'b1 && stage_0_data_vld === 1'b1) hs_count++;
    if (read_finish === 1'b1) check("read_finish_needs_valid", {31'b0, read_valid}, 32'd1);
    if (read_valid === 1'b1) begin
      rd_cnt++;
      if (exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_read: got addr=%0h expected no read", read_address);
      end else begin
        e = exp_rd_q.pop_front();
        check("read_address", {28'b0, read_address}, {28'b0, e.addr});
        check("read_finish", {31'b0, read_finish}, {31'b0, e.last});
        check("update_pass_run", {31'b0, update_pass}, {31'b0, e.upd});
      end
      if (read_finish === 1'b1) begin
        rf_cnt++;
        last_rf_cyc = cyc;
      end
    end
    if (state_finish === 1'b1) begin
      fin_count++;
      if (exp_fin_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_state_finish: got pulse expected none");
      end else begin
        f = exp_fin_q.pop_front();
        check("fin_load_phase", {30'b0, load_phase}, {30'b0, f.phase});
        check("fin_update_pass", {31'b0, update_pass}, {31'b0, f.upd});
        check("fin_latency", cyc - last_rf_cyc, PD + 1);
      end
    end
  end

  // Launch one pass with vld held high; mode flips and enable drops once RUN is reached.
  task automatic run_pass(input logic [3:0] tap, input logic [2:0] ld, input logic upd,
                          input logic keep);
    int rdy0;
    int fin0;
    int n;
    tap_length        = tap;
    load_length       = ld;
    error_update_mode = upd;
    stage_0_data_vld  = 1'b1;
    enable            = 1'b1;
    for (int a = 0; a <= int'(tap); a++)
      exp_rd_q.push_back('{addr: 4'(a), last: (a == int'(tap)), upd: upd});
    exp_fin_q.push_back('{phase: exp_phase, upd: upd});
    rdy0 = rdy_cycles;
    fin0 = fin_count;
    n = 0;
    while (fin_count == fin0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (busy && !stage_0_data_rdy) begin
        error_update_mode = ~upd;
        enable            = keep;
      end
    end
    if (fin_count == fin0) timeout("pass");
    check("rdy_cycles", rdy_cycles - rdy0, 32'(ld) + 32'd1);
    exp_phase = exp_phase + 2'd1;
  endtask

  initial begin
    int fin0;
    int hs0;
    int rd0;
    int rf0;
    int n;

    reset = 1'b1;
    enable = 1'b0;
    tap_length = 4'd0;
    load_length = 3'd0;
    stage_0_data_vld = 1'b0;
    stall = 1'b0;
    error_update_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_read_valid", {31'b0, read_valid}, 32'd0);
    check("rst_read_finish", {31'b0, read_finish}, 32'd0);
    check("rst_rdy", {31'b0, stage_0_data_rdy}, 32'd0);
    check("rst_state_finish", {31'b0, state_finish}, 32'd0);
    check("rst_update_pass", {31'b0, update_pass}, 32'd0);
    check("rst_load_phase", {30'b0, load_phase}, 32'd0);
    check("rst_read_address", {28'b0, read_address}, 32'd0);
    @(posedge clk);
    #2;

    // Basic pass, then the next pass must open in LOAD with phase 1.
    run_pass(4'd3, 3'd1, 1'b0, 1'b1);
    check("next_pass_rdy", {31'b0, stage_0_data_rdy}, 32'd1);
    check("next_pass_phase", {30'b0, load_phase}, 32'd1);

    // Back-to-back passes through the phase wrap.
    fin0 = fin_count;
    run_pass(4'd3, 3'd1, 1'b0, 1'b1);
    run_pass(4'd3, 3'd1, 1'b0, 1'b1);
    run_pass(4'd3, 3'd1, 1'b0, 1'b1);
    run_pass(4'd3, 3'd1, 1'b0, 1'b0);
    check("wrap_fin_count", fin_count - fin0, 32'd4);
    check("idle_after_pass", {31'b0, busy}, 32'd0);
    check("wrapped_phase", {30'b0, load_phase}, 32'd1);

    // Update-mode latching.
    run_pass(4'd2, 3'd1, 1'b1, 1'b1);
    run_pass(4'd2, 3'd1, 1'b0, 1'b0);

    // Degenerate lengths.
    run_pass(4'd0, 3'd0, 1'b0, 1'b0);

    // Bubbles during LOAD, stall during RUN, stall ignored in DRAIN.
    tap_length = 4'd2;
    load_length = 3'd1;
    stage_0_data_vld = 1'b0;
    error_update_mode = 1'b0;
    stall = 1'b0;
    enable = 1'b1;
    for (int a = 0; a <= 2; a++) exp_rd_q.push_back('{addr: 4'(a), last: (a == 2), upd: 1'b0});
    exp_fin_q.push_back('{phase: exp_phase, upd: 1'b0});
    hs0 = hs_count;
    rd0 = rd_cnt;
    rf0 = rf_cnt;
    fin0 = fin_count;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!stage_0_data_rdy && n < 50);
    if (!stage_0_data_rdy) timeout("load_entry");
    @(posedge clk); #1 stage_0_data_vld = 1'b1;
    @(posedge clk); #1 stage_0_data_vld = 1'b0;
    @(posedge clk); #1 stage_0_data_vld = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    check("bubble_rdy_low_in_run", {31'b0, stage_0_data_rdy}, 32'd0);
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr_hold", {28'b0, read_address}, 32'd1);
      check("stall_no_read", {31'b0, read_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    n = 0;
    while (fin_count == fin0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (busy && read_address == 4'd3) stall = 1'b1;
    end
    if (fin_count == fin0) timeout("stall_pass");
    stall = 1'b0;
    check("bubble_handshakes", hs_count - hs0, 32'd2);
    check("stall_total_reads", rd_cnt - rd0, 32'd3);
    check("stall_read_finish_once", rf_cnt - rf0, 32'd1);
    exp_phase = exp_phase + 2'd1;

    // Reset mid-RUN while address 2 is being read.
    tap_length = 4'd3;
    load_length = 3'd1;
    stage_0_data_vld = 1'b1;
    error_update_mode = 1'b0;
    enable = 1'b1;
    for (int a = 0; a <= 2; a++) exp_rd_q.push_back('{addr: 4'(a), last: 1'b0, upd: 1'b0});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(read_valid && read_address == 4'd2) && n < 50);
    if (!(read_valid && read_address == 4'd2)) timeout("reset_point");
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_read_valid", {31'b0, read_valid}, 32'd0);
    check("abort_load_phase", {30'b0, load_phase}, 32'd0);
    check("abort_state_finish", {31'b0, state_finish}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_phase = 2'd0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_reads_consumed", exp_rd_q.size(), 32'd0);
    run_pass(4'd3, 3'd1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("final_read_queue_empty", exp_rd_q.size(), 32'd0);
    check("final_fin_queue_empty", exp_fin_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
